// File: rtl/bcd_to_binary_pkg.sv
// Purpose: shared constants for the iterative BCD-to-binary converter.
// Latency: n/a (constants and a compile-time helper only).
// Backpressure: n/a.
//
// Contents: FSM state codes, parameter defaults, largest legal BCD digit,
// and the iteration-counter width helper.
package bcd_to_binary_pkg;

  // Parameter defaults: 3 digits (0..999) fit in 10 bits.
  localparam int DIGITS_DEFAULT = 3;
  localparam int BIN_W_DEFAULT  = 10;

  // FSM state encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Largest legal value of a single BCD digit.
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // The counter must be able to hold BIN_W itself.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(BIN_W_DEFAULT);

endpackage

// File: rtl/bcd_to_binary_digit_adjust.sv
// Purpose: per-digit correction step of reverse double-dabble.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
//
// Ports:
//   din  - one 4-bit BCD digit after the right shift
//   dout - din - 3 when din >= 8, otherwise din unchanged
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A digit >= 8 never underflows when 3 is subtracted, so 4 bits suffice.
  always_comb begin
    dout = din;
    if (din >= 4'd8) begin
      dout = din - 4'd3;
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Purpose: sequential reverse-double-dabble converter, packed BCD in, binary out.
// Latency: BIN_W+1 cycles from accepted start to done; 1 cycle on invalid input.
// Backpressure: start is honoured only in IDLE; requests while busy/done are dropped.
//
// Ports:
//   clk, reset - rising-edge clock, synchronous active-high reset
//   start      - conversion request, sampled in IDLE only
//   bcd_in     - packed BCD operand, digit 0 in bits [3:0]
//   busy       - high while shift steps are running
//   done       - one-cycle pulse when bin_out is valid
//   error      - one-cycle pulse alongside done if any input digit exceeded 9
//   bin_out    - converted value (0 on error), held until the next result
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT,
  parameter int BIN_W  = BIN_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = cnt_width(BIN_W);

  // Count value during the final shift step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  // Work register layout: {bcd_part, bin_part}.
  logic [WORK_W-1:0] work;
  // Remembers that the pending DONE cycle belongs to a rejected request.
  logic              err_flag;

  logic [WORK_W-1:0] shifted;
  logic [BCD_W-1:0]  bcd_adj;
  logic [WORK_W-1:0] work_next;
  logic              bcd_invalid;

  // One step: shift the whole register right, then correct every BCD digit.
  assign shifted = work >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (shifted[BIN_W + 4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  assign work_next = {bcd_adj, shifted[BIN_W-1:0]};

  // Any digit above 9 makes the request invalid.
  always_comb begin
    bcd_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX) begin
        bcd_invalid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      work     <= '0;
      err_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      bin_out  <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (bcd_invalid) begin
              // The rejection is reported immediately; the DONE cycle that
              // follows only holds off a new start and must not pulse again.
              state    <= S_DONE;
              err_flag <= 1'b1;
              done     <= 1'b1;
              error    <= 1'b1;
              bin_out  <= '0;
            end else begin
              state    <= S_SHIFT;
              work     <= {bcd_in, {BIN_W{1'b0}}};
              count    <= '0;
              err_flag <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          work  <= work_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          err_flag <= 1'b0;
          if (!err_flag) begin
            done    <= 1'b1;
            bin_out <= work[BIN_W-1:0];
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Every BCD bit has been shifted out into bin_part by the last step.
  a_bcd_drained: assert property (@(posedge clk) disable iff (reset)
    (state == S_DONE && !err_flag) |-> (work[WORK_W-1:BIN_W] == '0));

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  bin_out;

  bcd_to_binary dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    bit err;
    int cyc;   // expected negedge cycle of done, -1 = not checked
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   in_sweep = 1'b0;
  int   last_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("bin_out", int'(bin_out), e.bin);
        check("error", int'(error), int'(e.err));
        check("busy_at_done", int'(busy), 0);
        if (e.cyc >= 0) check("latency", cyc, e.cyc);
        if (in_sweep) begin
          if (last_done >= 0) check("spacing", cyc - last_done, 12);
          last_done = cyc;
        end
      end
    end
    if (!reset && error && !done) check("stray_error", 1, 0);
  end

  task automatic wait_done(input string nm);
    int i;
    i = 0;
    while (!done && i < 40) begin
      @(negedge clk);
      i++;
    end
    check({nm, "_timeout"}, int'(done), 1);
  endtask

  // Single conversion with a one-cycle start pulse; counts busy cycles.
  task automatic run_one(input logic [11:0] b, input int eb, input bit ee,
                         input string nm);
    int busy_cnt;
    int i;
    busy_cnt = 0;
    i = 0;
    bcd_in = b;
    start  = 1'b1;
    q.push_back('{eb, ee, cyc + 1 + (ee ? 0 : 11)});
    @(negedge clk);
    start = 1'b0;
    while (!done && i < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      i++;
    end
    check({nm, "_timeout"}, int'(done), 1);
    check({nm, "_busy_cycles"}, busy_cnt, ee ? 0 : 10);
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_bin_out", int'(bin_out), 0);
    reset = 1'b0;
    @(negedge clk);

    run_one(12'h255, 255, 1'b0, "c255");
    run_one(12'h999, 999, 1'b0, "c999");
    run_one(12'h000, 0,   1'b0, "c000");
    run_one(12'h100, 100, 1'b0, "c100");
    run_one(12'h1A3, 0,   1'b1, "c1A3");
    run_one(12'h042, 42,  1'b0, "c042");

    // Start while busy is ignored and bcd_in is not resampled.
    bcd_in = 12'h123;
    start  = 1'b1;
    q.push_back('{123, 1'b0, cyc + 12});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bcd_in = 12'h456;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("c123");
    @(negedge clk);
    run_one(12'h456, 456, 1'b0, "c456");

    // Reset mid-conversion discards the work and suppresses done.
    bcd_in = 12'h777;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_bin_out", int'(bin_out), 0);
    check("midrst_done", int'(done), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    run_one(12'h007, 7, 1'b0, "c007");

    // Back-to-back sweep with start held high.
    in_sweep = 1'b1;
    start    = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int t;
      t = 0;
      bcd_in = to_bcd(i);
      while (busy && t < 40) begin
        @(negedge clk);
        t++;
      end
      while (!busy && t < 80) begin
        @(negedge clk);
        t++;
      end
      if (!busy) begin
        check("sweep_accept", 0, 1);
        break;
      end
      q.push_back('{i, 1'b0, -1});
    end
    start = 1'b0;

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    check("queue_drain", q.size(), 0);
    in_sweep = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
